// File: rtl/cfg_seq_pkg.sv
// Shared definitions for the config-ROM sequencer.
// - ROM entry opcodes.
// - FSM state encoding.
// - Entry field layout helpers, parametrised on register-address and data widths.
// - Delay tick helper.
// A ROM entry is packed as {op[1:0], reg[RA_W-1:0], data[D_W-1:0]}.
package cfg_seq_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_WRITE        = 2'b00;
  localparam opcode_t OP_WRITE_VERIFY = 2'b01;
  localparam opcode_t OP_DELAY        = 2'b10;
  localparam opcode_t OP_END          = 2'b11;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_ISSUE_WR = 4'd3;
  localparam logic [3:0] ST_WAIT_HI  = 4'd4;
  localparam logic [3:0] ST_WAIT_LO  = 4'd5;
  localparam logic [3:0] ST_ISSUE_RD = 4'd6;
  localparam logic [3:0] ST_RD_HI    = 4'd7;
  localparam logic [3:0] ST_RD_LO    = 4'd8;
  localparam logic [3:0] ST_RETRY    = 4'd9;
  localparam logic [3:0] ST_NEXT     = 4'd10;
  localparam logic [3:0] ST_DLY      = 4'd11;
  localparam logic [3:0] ST_DONE     = 4'd12;
  localparam logic [3:0] ST_END_SEQ  = 4'd13;

  // Delay counts are at most 255 units regardless of D_W.
  localparam int DLY_UNITS_W = 8;

  function automatic int entry_w(input int ra_w, input int d_w);
    return 2 + ra_w + d_w;
  endfunction

  function automatic int op_lsb(input int ra_w, input int d_w);
    return ra_w + d_w;
  endfunction

  function automatic int reg_lsb(input int d_w);
    return d_w;
  endfunction

  function automatic int delay_ticks(input int t_clk, input int unit_ns);
    return unit_ns / t_clk;
  endfunction

endpackage

// File: rtl/cfg_sequencer_if.sv
// Bundle of all sequencer-facing signals.
// It carries the start/status handshake, the config ROM port and the I2C/SCCB command master port.
// - modport master: the sequencer side.
// - modport slave: the environment side (ROM, master, top-level control).
// Signal names keep the sequencer's port names so the direction of each signal stays
// obvious when read through the interface.
interface cfg_sequencer_if
  import cfg_seq_pkg::*;
#(
  parameter int ROM_AW = 8,
  parameter int RA_W   = 8,
  parameter int D_W    = 8
);
  logic                          i_start;
  logic                          o_busy;
  logic                          o_done;
  logic                          o_error;
  logic [ROM_AW-1:0]             o_err_addr;
  logic [ROM_AW-1:0]             o_rom_addr;
  logic [entry_w(RA_W, D_W)-1:0] i_rom_data;
  logic                          o_wr;
  logic                          o_rd;
  logic [RA_W-1:0]               o_reg_addr;
  logic [D_W-1:0]                o_wdata;
  logic                          i_m_busy;
  logic [D_W-1:0]                i_m_rdata;
  logic                          i_m_rdata_valid;
  logic                          i_m_nack;

  modport master (
    input  i_start, i_rom_data, i_m_busy, i_m_rdata, i_m_rdata_valid, i_m_nack,
    output o_busy, o_done, o_error, o_err_addr, o_rom_addr,
           o_wr, o_rd, o_reg_addr, o_wdata
  );

  modport slave (
    output i_start, i_rom_data, i_m_busy, i_m_rdata, i_m_rdata_valid, i_m_nack,
    input  o_busy, o_done, o_error, o_err_addr, o_rom_addr,
           o_wr, o_rd, o_reg_addr, o_wdata
  );
endinterface

// File: rtl/cfg_delay_timer.sv
// Down-counter for DELAY entries.
// Ports:
// - clk: clock.
// - rst: synchronous active-high reset.
// - load: loads units*(DELAY_UNIT_NS/T_CLK)-1.
// - units: delay count in DELAY_UNIT_NS units (1..255; 0 is handled by the caller).
// - run: decrement enable.
// - zero: count has reached 0.
// With load followed by run, zero rises after units*ticks cycles.
module cfg_delay_timer
  import cfg_seq_pkg::*;
#(
  parameter int T_CLK         = 8,
  parameter int DELAY_UNIT_NS = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DLY_UNITS_W-1:0] units,
  input  logic                   run,
  output logic                   zero
);
  localparam int TICKS  = delay_ticks(T_CLK, DELAY_UNIT_NS);
  localparam int TW_RAW = $clog2(255 * TICKS);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(32'(units) * TICKS - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cfg_sequencer.sv
// Config-ROM sequencer.
// It walks an external registered ROM from address 0.
// - Each entry is issued as a register write to a command-style I2C/SCCB master.
// - WRITE_VERIFY entries are optionally read back and compared.
// - A failing entry (NACK or compare mismatch) is retried up to MAX_RETRY extra times.
// - DELAY entries insert programmable waits.
// - The sequence stops on END, or on retry exhaustion with o_error/o_err_addr.
// Ports:
// - i_clk, i_rst: clock and synchronous active-high reset.
// - bus (master modport): start/busy/done/error status, ROM address/data and the master command port.
module cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int T_CLK         = 8,
  parameter int ROM_AW        = 8,
  parameter int RA_W          = 8,
  parameter int D_W           = 8,
  parameter int MAX_RETRY     = 3,
  parameter int DELAY_UNIT_NS = 1_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  cfg_sequencer_if.master bus
);
  localparam int OP_LSB  = op_lsb(RA_W, D_W);
  localparam int REG_LSB = reg_lsb(D_W);
  localparam int RC_W    = $clog2(MAX_RETRY + 2);

  opcode_t                ent_op;
  logic [RA_W-1:0]        ent_reg;
  logic [D_W-1:0]         ent_data;
  logic [DLY_UNITS_W-1:0] ent_units;

  logic [3:0]             state;
  opcode_t                op_q;
  logic [RC_W-1:0]        retry_cnt;
  logic                   rd_got;
  logic [D_W-1:0]         rd_cap;
  logic                   rd_bad;
  logic                   tmr_load;
  logic                   tmr_zero;

  assign ent_op    = bus.i_rom_data[OP_LSB +: 2];
  assign ent_reg   = bus.i_rom_data[REG_LSB +: RA_W];
  assign ent_data  = bus.i_rom_data[D_W-1:0];
  assign ent_units = DLY_UNITS_W'(ent_data);

  // A zero-length DELAY skips the timer entirely, so the load never underflows.
  assign tmr_load = (state == ST_DECODE) && (ent_op == OP_DELAY) && (ent_units != '0);

  // Read data may arrive together with the busy fall, so the live strobe takes
  // priority over the captured value.
  always_comb begin
    rd_bad = 1'b0;
    if (bus.i_m_rdata_valid) begin
      rd_bad = (bus.i_m_rdata != bus.o_wdata);
    end else begin
      rd_bad = !rd_got || (rd_cap != bus.o_wdata);
    end
  end

  cfg_delay_timer #(
    .T_CLK        (T_CLK),
    .DELAY_UNIT_NS(DELAY_UNIT_NS)
  ) u_timer (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (tmr_load),
    .units(ent_units),
    .run  (state == ST_DLY),
    .zero (tmr_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      op_q           <= OP_WRITE;
      retry_cnt      <= '0;
      rd_got         <= 1'b0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_error    <= 1'b0;
      bus.o_err_addr <= '0;
      bus.o_rom_addr <= '0;
      bus.o_wr       <= 1'b0;
      bus.o_rd       <= 1'b0;
      bus.o_reg_addr <= '0;
      bus.o_wdata    <= '0;
    end else begin
      // Request strobes are single-cycle unless re-asserted below.
      bus.o_wr <= 1'b0;
      bus.o_rd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            bus.o_done     <= 1'b0;
            bus.o_error    <= 1'b0;
            bus.o_rom_addr <= '0;
            bus.o_busy     <= 1'b1;
            retry_cnt      <= '0;
            state          <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          op_q <= ent_op;
          case (ent_op)
            OP_END:   state <= ST_DONE;
            OP_DELAY: state <= (ent_units == '0) ? ST_NEXT : ST_DLY;
            default: begin
              bus.o_reg_addr <= ent_reg;
              bus.o_wdata    <= ent_data;
              // Issue straight from decode when the master is free; this keeps
              // the post-delay write latency close to the programmed delay.
              if (!bus.i_m_busy) begin
                bus.o_wr <= 1'b1;
                state    <= ST_WAIT_HI;
              end else begin
                state <= ST_ISSUE_WR;
              end
            end
          endcase
        end
        ST_ISSUE_WR: begin
          if (!bus.i_m_busy) begin
            bus.o_wr <= 1'b1;
            state    <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: if (bus.i_m_busy) state <= ST_WAIT_LO;
        ST_WAIT_LO: begin
          if (!bus.i_m_busy) begin
            if (bus.i_m_nack)                  state <= ST_RETRY;
            else if (op_q == OP_WRITE_VERIFY)  state <= ST_ISSUE_RD;
            else                               state <= ST_NEXT;
          end
        end
        ST_ISSUE_RD: begin
          if (!bus.i_m_busy) begin
            bus.o_rd <= 1'b1;
            rd_got   <= 1'b0;
            state    <= ST_RD_HI;
          end
        end
        ST_RD_HI, ST_RD_LO: begin
          if (bus.i_m_rdata_valid) begin
            rd_got <= 1'b1;
            rd_cap <= bus.i_m_rdata;
          end
          if ((state == ST_RD_HI) && bus.i_m_busy) begin
            state <= ST_RD_LO;
          end else if ((state == ST_RD_LO) && !bus.i_m_busy) begin
            state <= (bus.i_m_nack || rd_bad) ? ST_RETRY : ST_NEXT;
          end
        end
        ST_RETRY: begin
          if (retry_cnt < RC_W'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= ST_ISSUE_WR;
          end else begin
            bus.o_err_addr <= bus.o_rom_addr;
            bus.o_error    <= 1'b1;
            state          <= ST_END_SEQ;
          end
        end
        ST_NEXT: begin
          retry_cnt <= '0;
          // Running off the top of the ROM is treated as an END entry.
          if (bus.o_rom_addr == '1) begin
            state <= ST_DONE;
          end else begin
            bus.o_rom_addr <= bus.o_rom_addr + 1'b1;
            state          <= ST_FETCH;
          end
        end
        ST_DLY: if (tmr_zero) state <= ST_NEXT;
        ST_DONE: begin
          bus.o_done <= 1'b1;
          state      <= ST_END_SEQ;
        end
        ST_END_SEQ: begin
          bus.o_busy <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_sequencer.sv
module tb_cfg_sequencer;
  import cfg_seq_pkg::*;

  typedef struct packed {
    logic       rd;
    logic [7:0] ra;
    logic [7:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  cfg_sequencer_if #(.ROM_AW(8), .RA_W(8), .D_W(8)) bus ();

  cfg_sequencer #(
    .T_CLK(8), .ROM_AW(8), .RA_W(8), .D_W(8),
    .MAX_RETRY(3), .DELAY_UNIT_NS(1000)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  txn_t exp_q[$];

  logic [17:0] rom [0:255];
  logic [7:0]  nack_addr;
  int          nack_n;
  logic [7:0]  rb_val;

  // Registered ROM, one cycle of latency.
  always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

  // Master model: busy for 4 cycles per request; NACK and read data appear on the busy fall.
  int   m_cnt;
  logic m_is_rd;
  logic m_nack_pend;
  int   wr_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt               <= 0;
      m_is_rd             <= 1'b0;
      m_nack_pend         <= 1'b0;
      wr_cnt              <= 0;
      bus.i_m_busy        <= 1'b0;
      bus.i_m_nack        <= 1'b0;
      bus.i_m_rdata       <= '0;
      bus.i_m_rdata_valid <= 1'b0;
    end else begin
      bus.i_m_rdata_valid <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          bus.i_m_busy <= 1'b0;
          bus.i_m_nack <= m_nack_pend;
          if (m_is_rd) begin
            bus.i_m_rdata_valid <= 1'b1;
            bus.i_m_rdata       <= rb_val;
          end
        end
      end else if (bus.o_wr || bus.o_rd) begin
        bus.i_m_busy <= 1'b1;
        m_cnt        <= 4;
        m_is_rd      <= bus.o_rd;
        m_nack_pend  <= bus.o_wr && (bus.o_rom_addr == nack_addr) && (wr_cnt < nack_n);
        if (bus.o_wr && (bus.o_rom_addr == nack_addr)) wr_cnt <= wr_cnt + 1;
      end
      if (bus.i_start) wr_cnt <= 0;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ent(input logic [1:0] op, input logic [7:0] r, input logic [7:0] d);
    return {op, r, d};
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = ent(OP_END, 8'h00, 8'h00);
  endtask

  task automatic push(input logic rd, input logic [7:0] ra, input logic [7:0] d);
    txn_t t;
    t.rd = rd; t.ra = ra; t.d = d;
    exp_q.push_back(t);
  endtask

  task automatic chk_rst(input string pfx);
    check_val({pfx, "_busy"},     bus.o_busy, 0);
    check_val({pfx, "_done"},     bus.o_done, 0);
    check_val({pfx, "_error"},    bus.o_error, 0);
    check_val({pfx, "_err_addr"}, bus.o_err_addr, 0);
    check_val({pfx, "_rom_addr"}, bus.o_rom_addr, 0);
    check_val({pfx, "_wr"},       bus.o_wr, 0);
    check_val({pfx, "_rd"},       bus.o_rd, 0);
    check_val({pfx, "_reg_addr"}, bus.o_reg_addr, 0);
    check_val({pfx, "_wdata"},    bus.o_wdata, 0);
  endtask

  // Starts a sequence and scores every request against the expectation queue
  // until busy drops. first_wr is the cycle (edges after the start edge) of the first o_wr.
  task automatic run_seq(input int budget, input int mid_start, output int first_wr);
    int   cyc;
    logic fin;
    txn_t e;
    first_wr = -1;
    cyc = 0;
    fin = 1'b0;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    while (!fin && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      bus.i_start = (cyc == mid_start);
      if (bus.o_wr && bus.o_rd) check_val("wr_rd_excl", 1, 0);
      if (bus.o_wr || bus.o_rd) begin
        if (bus.o_wr && first_wr < 0) first_wr = cyc;
        if (exp_q.size() == 0) begin
          check_val("unexp_req", {bus.o_rd, bus.o_reg_addr, bus.o_wdata}, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("req_kind", bus.o_rd, e.rd);
          check_val("req_reg", bus.o_reg_addr, e.ra);
          if (bus.o_wr) check_val("req_wdata", bus.o_wdata, e.d);
        end
      end
      if (!bus.o_busy) fin = 1'b1;
    end
    bus.i_start = 1'b0;
    if (!fin) check_val("timeout", 0, 1);
    check_val("sb_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  int   fw;
  logic seen;

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    nack_addr = 8'hFF;
    nack_n = 0;
    rb_val = 8'h00;
    rom_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_rst("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain writes
    rom_clear();
    rom[0] = ent(OP_WRITE, 8'h12, 8'h80);
    rom[1] = ent(OP_WRITE, 8'h11, 8'h01);
    push(0, 8'h12, 8'h80);
    push(0, 8'h11, 8'h01);
    run_seq(2000, 0, fw);
    check_val("wr_done", bus.o_done, 1);
    check_val("wr_error", bus.o_error, 0);
    check_val("wr_busy", bus.o_busy, 0);

    // Delay of 2 units = 250 cycles; DELAY is decoded 2 edges after the start edge.
    rom_clear();
    rom[0] = ent(OP_DELAY, 8'h00, 8'd2);
    rom[1] = ent(OP_WRITE, 8'h40, 8'h10);
    push(0, 8'h40, 8'h10);
    run_seq(2000, 0, fw);
    check_val("dly_latency", ((fw - 2) >= 247 && (fw - 2) <= 253) ? 250 : (fw - 2), 250);
    check_val("dly_done", bus.o_done, 1);

    // Verify pass
    rom_clear();
    rom[0] = ent(OP_WRITE_VERIFY, 8'h3A, 8'h04);
    rb_val = 8'h04;
    push(0, 8'h3A, 8'h04);
    push(1, 8'h3A, 8'h04);
    run_seq(2000, 0, fw);
    check_val("vfy_done", bus.o_done, 1);
    check_val("vfy_error", bus.o_error, 0);

    // Verify mismatch -> 1 + MAX_RETRY pairs, then error
    rb_val = 8'h05;
    for (int i = 0; i < 4; i++) begin
      push(0, 8'h3A, 8'h04);
      push(1, 8'h3A, 8'h04);
    end
    run_seq(2000, 0, fw);
    check_val("vbad_error", bus.o_error, 1);
    check_val("vbad_err_addr", bus.o_err_addr, 0);
    check_val("vbad_done", bus.o_done, 0);

    // NACK twice on entry 1, ACK on third attempt
    rom_clear();
    rom[0] = ent(OP_WRITE, 8'h20, 8'hAA);
    rom[1] = ent(OP_WRITE, 8'h21, 8'hBB);
    nack_addr = 8'h01;
    nack_n = 2;
    push(0, 8'h20, 8'hAA);
    for (int i = 0; i < 3; i++) push(0, 8'h21, 8'hBB);
    run_seq(2000, 0, fw);
    check_val("nack_done", bus.o_done, 1);
    check_val("nack_error", bus.o_error, 0);
    nack_n = 0;

    // Start while busy (during the delay after the write) must be ignored
    rom_clear();
    rom[0] = ent(OP_WRITE, 8'h40, 8'h10);
    rom[1] = ent(OP_DELAY, 8'h00, 8'd1);
    push(0, 8'h40, 8'h10);
    run_seq(2000, 60, fw);
    check_val("ign_done", bus.o_done, 1);

    // Reset in the middle of a delay
    rom_clear();
    rom[0] = ent(OP_DELAY, 8'h00, 8'd5);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("dly_mid_busy", bus.o_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_rst("rst_dly");
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.o_wr || bus.o_rd || bus.o_busy) seen = 1'b1;
    end
    check_val("rst_dly_quiet", seen, 0);

    // Restart from address 0 after the abort
    rom_clear();
    rom[0] = ent(OP_WRITE, 8'h12, 8'h80);
    push(0, 8'h12, 8'h80);
    run_seq(2000, 0, fw);
    check_val("restart_done", bus.o_done, 1);

    // Reset while waiting for the master to finish a write
    rom_clear();
    rom[0] = ent(OP_WRITE, 8'h55, 8'h66);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.o_wr) seen = 1'b1;
    end
    check_val("wlo_wr_seen", seen, 1);
    repeat (2) @(posedge clk);
    #1;
    check_val("wlo_m_busy", bus.i_m_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_rst("rst_wlo");
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.o_wr || bus.o_rd || bus.o_busy) seen = 1'b1;
    end
    check_val("rst_wlo_quiet", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
